mem_stream_reader: RTL and testbench
====================================

# mem_stream_reader

Sequential read master for the 8192×8 single-port block RAM (`blk_mem_gen_0`, 13-bit address, 8-bit data, 1-cycle read latency). On a `start` pulse it reads `length` consecutive bytes from `base_addr`, wrapping modulo 8192. It emits the bytes in order as a valid/ready stream, and a small FIFO absorbs backpressure. It is the read side of the memory: the writer fills the RAM through the same port signals, and this block drains it toward display and processing logic.

## Interface
- `ADDR_W`, 13, RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 8, RAM data width.
- `clk`  in  1  clock; all registers on rising edge.
- `rst`  in  1  reset. Asynchronous assert, active-high. Synchronous deassert is handled by the integrator.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first address. Captured with `start`.
- `length`  in  ADDR_W+1  byte count, 0..8192. Captured with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until the last handshake.
- `done`  out  1  one-cycle pulse at completion.
- `mem_ena`  out  1  RAM enable. Read strobe.
- `mem_wea`  out  1  RAM write enable. Constant 0.
- `mem_addra`  out  ADDR_W  RAM address.
- `mem_douta`  in  DATA_W  RAM read data. Valid the cycle after `mem_ena`.
- `m_data`  out  DATA_W  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from consumer.

## Operation
- FSM states are IDLE, READ, DRAIN, DONE.
- IDLE → READ on `start`. Latch `base_addr` into the address counter and `length` into the remaining counter.
- If `length`=0: IDLE → DONE directly. No RAM access and no stream beats.
- READ: issue a read when `remaining>0` and `fifo_count + inflight < 3`.
  - `inflight` is 1 if `mem_ena` was high last cycle.
  - On each issue: address counter +1 (wraps 8191→0), `remaining` −1.
- READ → DRAIN when `remaining` reaches 0.
- DRAIN → DONE when `inflight`=0, the FIFO is empty, and no pop is pending.
- DONE lasts one cycle, drives `done`=1, then returns to IDLE.
- FIFO: depth 3.
  - Push: the cycle after each issue, capturing `mem_douta`.
  - Pop: on `m_valid && m_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by the credit rule.
- `m_data` is the FIFO head. It is stable while `m_valid && !m_ready`.
- `m_valid` does not depend on `m_ready`.
- `mem_ena` and `mem_addra` are decoded from registers only. There is no combinational path from `m_ready` or `start` to RAM pins.
- `mem_addra` holds the last value when `mem_ena`=0.
- `start` while not IDLE is ignored. Parameters are not re-latched.
- Reset at any point:
  - All state is cleared immediately and the FSM goes to IDLE.
  - In-flight RAM data is discarded and the FIFO is emptied.
  - No `done` pulse is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_ena`=0, `mem_wea`=0, `mem_addra`=0, `m_valid`=0, `m_data`=0.
- `start` is sampled at edge E0. `mem_ena`=1 with `mem_addra`=base during the cycle after E0. First `m_valid` is high after E2, two cycles after the first read.
- Throughput with `m_ready` held high: one byte per cycle sustained. Total `length`+3 cycles from `start` to `done`.
- `busy` falls and `done` pulses in the cycle after the final handshake edge.
- With `m_ready` low, at most 3 reads are outstanding or buffered. Then `mem_ena` stays low until a pop.

## Configuration
- `MEM_STREAM_READER_LAST_EN` defined:
  - Adds output port `m_last` (1 bit), high with the final beat of a transfer.
  - `m_last` is stored alongside each FIFO entry and resets to 0.
- Undefined: no `m_last` port and no extra FIFO bit. All other behaviour is identical.

## Test plan
- RAM preloaded [0]=100, [1]=130, [2]=200; `start`, base=0, length=3, `m_ready`=1 → beats 100, 130, 200 on consecutive cycles. First `m_valid` is 2 cycles after the first `mem_ena`. One `done` pulse. `mem_wea` is never 1.
- base=8190, length=4 → `mem_addra` sequence 8190, 8191, 0, 1. Data is in the same order.
- length=5, `m_ready` low for 6 cycles then high → exactly 3 reads issued, then `mem_ena` stays low. `m_data` is stable while stalled. All 5 bytes arrive in order with no loss or duplication.
- length=0 → `done` pulses once, `busy` pulses once, and neither `mem_ena` nor `m_valid` is ever asserted. A second `start` during `busy` of a length-8 transfer has no effect.
- `rst` asserted mid-transfer (after 2 of 6 beats) → all outputs go to reset values immediately, with no `done`. A new `start`, base=0, length=3, then streams 100, 130, 200 correctly.
- With `MEM_STREAM_READER_LAST_EN`: length=3 → `m_last`=1 only on the beat 200. For length=1 it is 1 on the single beat.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Sequential read master: streams `length` bytes from a 1-cycle-latency RAM through a 3-deep FIFO.
// Optional MEM_STREAM_READER_LAST_EN adds an m_last sideband carried through the FIFO.
module mem_stream_reader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  input  logic [DATA_W-1:0] mem_douta,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
`ifdef MEM_STREAM_READER_LAST_EN
  output logic              m_last,
`endif
  input  logic              m_ready
);

  localparam int FIFO_D = 3;
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   L_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                ena_q, ena_d;
  logic                rd_vld_q, rd_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo_q [FIFO_D];
  logic [DATA_W-1:0]   fifo_d [FIFO_D];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                push, pop;
  logic [2:0]          pending;
`ifdef MEM_STREAM_READER_LAST_EN
  logic                ena_last_q, ena_last_d;
  logic                rd_last_q, rd_last_d;
  logic                fifo_last_q [FIFO_D];
  logic                fifo_last_d [FIFO_D];
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    ena_d    = 1'b0;
    rd_vld_d = ena_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
`ifdef MEM_STREAM_READER_LAST_EN
    ena_last_d  = 1'b0;
    rd_last_d   = ena_last_q;
    fifo_last_d = fifo_last_q;
`endif

    push = rd_vld_q;
    pop  = (cnt_q != 2'd0) && m_ready;
    // Credit covers buffered entries plus both RAM pipeline stages; a same-cycle pop frees one.
    pending = {1'b0, cnt_q} + {2'b0, rd_vld_q} + {2'b0, ena_q} - {2'b0, pop};

    if (push) begin
      fifo_d[wr_ptr_q] = mem_douta;
`ifdef MEM_STREAM_READER_LAST_EN
      fifo_last_d[wr_ptr_q] = rd_last_q;
`endif
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // First read goes out straight from IDLE so mem_ena rises the cycle after start.
            state_d = S_READ;
            ena_d   = 1'b1;
            addr_d  = base_addr;
            rem_d   = length - L_ONE;
`ifdef MEM_STREAM_READER_LAST_EN
            ena_last_d = (length == L_ONE);
`endif
          end
        end
      end
      S_READ: begin
        if (rem_q == '0) begin
          state_d = S_DRAIN;
        end else if (pending < 3'd3) begin
          ena_d  = 1'b1;
          addr_d = addr_q + A_ONE;
          rem_d  = rem_q - L_ONE;
`ifdef MEM_STREAM_READER_LAST_EN
          ena_last_d = (rem_q == L_ONE);
`endif
          if (rem_q == L_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ena_q && !rd_vld_q && (cnt_d == 2'd0)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      ena_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 2'd0;
`ifdef MEM_STREAM_READER_LAST_EN
      ena_last_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      fifo_last_q <= '{default: 1'b0};
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      ena_q    <= ena_d;
      rd_vld_q <= rd_vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef MEM_STREAM_READER_LAST_EN
      ena_last_q  <= ena_last_d;
      rd_last_q   <= rd_last_d;
      fifo_last_q <= fifo_last_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_ena   = ena_q;
  assign mem_wea   = 1'b0;
  assign mem_addra = addr_q;
  assign m_data    = fifo_q[rd_ptr_q];
  assign m_valid   = (cnt_q != 2'd0);
`ifdef MEM_STREAM_READER_LAST_EN
  assign m_last    = m_valid && fifo_last_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: behavioural RAM, scoreboard queue of expected beats.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [13:0] length = '0;
  logic        busy, done, mem_ena, mem_wea;
  logic [12:0] mem_addra;
  logic [7:0]  mem_douta;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
`ifdef MEM_STREAM_READER_LAST_EN
  logic        m_last;
`endif

  mem_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_douta(mem_douta),
    .m_data(m_data), .m_valid(m_valid),
`ifdef MEM_STREAM_READER_LAST_EN
    .m_last(m_last),
`endif
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [8192];
  always @(posedge clk) if (mem_ena) mem_douta <= ram[mem_addra];

  typedef struct { logic [7:0] data; logic last; } exp_t;
  exp_t sb_q [$];

  int n_checks = 0, n_err = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt, busy_cnt, wea_hi = 0, ena_cnt, valid_cnt, beat_cnt;
  int first_ena, first_valid, last_valid, done_cyc;
  int addr_log [$];
  bit stalled;
  logic [7:0] stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_mon();
    done_cnt = 0; busy_cnt = 0; ena_cnt = 0; valid_cnt = 0; beat_cnt = 0;
    first_ena = -1; first_valid = -1; last_valid = -1; done_cyc = -1;
    addr_log.delete();
    stalled = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (mem_wea) wea_hi++;
    if (mem_ena) begin
      ena_cnt++;
      addr_log.push_back(int'(mem_addra));
      if (first_ena < 0) first_ena = cyc;
    end
    if (m_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    if (m_valid && !m_ready) begin
      if (stalled) check("stall_data_stable", m_data, stall_data);
      stalled = 1'b1;
      stall_data = m_data;
    end else begin
      stalled = 1'b0;
    end
    if (m_valid && m_ready) begin
      exp_t e;
      beat_cnt++;
      check("beat_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("beat_data", m_data, e.data);
`ifdef MEM_STREAM_READER_LAST_EN
        check("beat_last", m_last, e.last);
`endif
      end
    end
  end

  task automatic do_start(input int base, input int len, input bit expect_it);
    start = 1'b1;
    base_addr = 13'(base);
    length = 14'(len);
    if (expect_it)
      for (int i = 0; i < len; i++) begin
        exp_t e;
        e.data = ram[(base + i) % 8192];
        e.last = (i == len - 1);
        sb_q.push_back(e);
      end
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    #1 check("done_seen", done_cnt > 0, 1);
  endtask

  initial begin
    int exp_a [4];
    for (int i = 0; i < 8192; i++) ram[i] = 8'(i * 37 + 11);
    ram[0] = 8'd100; ram[1] = 8'd130; ram[2] = 8'd200;
    reset_mon();

    // Reset values while rst is held
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ena", mem_ena, 0);
    check("rst_wea", mem_wea, 0);
    check("rst_addr", mem_addra, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic 3-byte read, m_ready high
    m_ready = 1'b1;
    reset_mon();
    do_start(0, 3, 1);
    check("t1_ena_after_start", mem_ena, 1);
    check("t1_addr_after_start", mem_addra, 0);
    check("t1_busy_after_start", busy, 1);
    wait_done(50);
    check("t1_start_to_done", done_cyc - start_cyc, 6);
    check("t1_first_valid_lat", first_valid - first_ena, 2);
    check("t1_valid_cycles", valid_cnt, 3);
    check("t1_consecutive", last_valid - first_valid, 2);
    check("t1_beats", beat_cnt, 3);
    check("t1_sb_empty", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("t1_one_done", done_cnt, 1);

    // Single-beat transfer
    reset_mon();
    do_start(5, 1, 1);
    wait_done(50);
    check("t1b_beats", beat_cnt, 1);
    check("t1b_sb_empty", sb_q.size(), 0);

    // Address wrap at the top of memory
    reset_mon();
    do_start(8190, 4, 1);
    check("t2_addr_first", mem_addra, 8190);
    wait_done(50);
    exp_a = '{8190, 8191, 0, 1};
    check("t2_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("t2_addr_seq", addr_log[i], exp_a[i]);
    check("t2_start_to_done", done_cyc - start_cyc, 7);
    check("t2_sb_empty", sb_q.size(), 0);

    // Backpressure: m_ready low for 6 cycles
    m_ready = 1'b0;
    reset_mon();
    do_start(20, 5, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t3_reads_stalled", ena_cnt, 3);
    check("t3_ena_low", mem_ena, 0);
    check("t3_valid_stalled", m_valid, 1);
    m_ready = 1'b1;
    wait_done(50);
    check("t3_reads_total", ena_cnt, 5);
    check("t3_beats", beat_cnt, 5);
    check("t3_sb_empty", sb_q.size(), 0);

    // Zero length
    reset_mon();
    do_start(0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t4_done_cnt", done_cnt, 1);
    check("t4_busy_cnt", busy_cnt, 1);
    check("t4_ena_cnt", ena_cnt, 0);
    check("t4_valid_cnt", valid_cnt, 0);

    // Start while busy is ignored
    reset_mon();
    do_start(10, 8, 1);
    repeat (2) @(posedge clk);
    #1 do_start(100, 2, 0);
    wait_done(100);
    repeat (5) @(posedge clk);
    #1;
    check("t4b_done_cnt", done_cnt, 1);
    check("t4b_beats", beat_cnt, 8);
    check("t4b_reads", ena_cnt, 8);
    check("t4b_sb_empty", sb_q.size(), 0);

    // Reset mid-transfer after two beats
    reset_mon();
    do_start(0, 6, 1);
    for (int i = 0; i < 50 && beat_cnt < 2; i++) @(posedge clk);
    check("t5_two_beats", beat_cnt, 2);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_ena", mem_ena, 0);
    check("t5_rst_addr", mem_addra, 0);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_data", m_data, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t5_no_done", done_cnt, 0);
    reset_mon();
    do_start(0, 3, 1);
    wait_done(50);
    check("t5_restart_beats", beat_cnt, 3);
    check("t5_restart_sb_empty", sb_q.size(), 0);

    check("wea_never_high", wea_hi, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
